// File: rtl/core_sequencer_pkg.sv
// Shared definitions for the core sequencer and the pipeline stages that decode its state.
// The state encodings are broadcast to every stage and must not be renumbered.
package core_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WRITE  = 3'd4,
        ST_HALT   = 3'd5
    } core_state_e;

    localparam logic [31:0] PC_STEP = 32'd4;

    function automatic logic is_misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/core_sequencer.sv
// Multi-cycle core sequencer: steps one instruction at a time through
// fetch/decode/execute/memory/writeback and owns the PC and retire count.
module core_sequencer
    import core_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rstn,
    output logic [2:0]  state,
    output logic [31:0] pc,
    output logic        fetch_req,
    input  logic        fetch_ack,
    output logic        mem_req,
    output logic        mem_we,
    input  logic        mem_ack,
    input  logic        mem_read_enabled,
    input  logic        mem_write_enabled,
    input  logic        reg_write_enabled,
    input  logic        is_jump_enabled,
    input  logic [31:0] jump_dest,
    input  logic        halt_req,
    output logic        reg_commit,
    output logic        halted,
    output logic        misalign,
    output logic [31:0] instret
);

    core_state_e state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instret_q, instret_d;
    logic        fetch_req_q, fetch_req_d;
    logic        mem_phase_q, mem_phase_d;
    logic        halted_q, halted_d;
    logic        misalign_q, misalign_d;
    logic        lat_read_q, lat_read_d;
    logic        lat_write_q, lat_write_d;
    logic        lat_reg_write_q, lat_reg_write_d;
    logic        lat_jump_q, lat_jump_d;
    logic [31:0] lat_dest_q, lat_dest_d;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q         <= ST_FETCH;
            pc_q            <= RESET_PC;
            instret_q       <= 32'd0;
            fetch_req_q     <= 1'b0;
            mem_phase_q     <= 1'b0;
            halted_q        <= 1'b0;
            misalign_q      <= 1'b0;
            lat_read_q      <= 1'b0;
            lat_write_q     <= 1'b0;
            lat_reg_write_q <= 1'b0;
            lat_jump_q      <= 1'b0;
            lat_dest_q      <= 32'd0;
        end else begin
            state_q         <= state_d;
            pc_q            <= pc_d;
            instret_q       <= instret_d;
            fetch_req_q     <= fetch_req_d;
            mem_phase_q     <= mem_phase_d;
            halted_q        <= halted_d;
            misalign_q      <= misalign_d;
            lat_read_q      <= lat_read_d;
            lat_write_q     <= lat_write_d;
            lat_reg_write_q <= lat_reg_write_d;
            lat_jump_q      <= lat_jump_d;
            lat_dest_q      <= lat_dest_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        pc_d            = pc_q;
        instret_d       = instret_q;
        fetch_req_d     = fetch_req_q;
        mem_phase_d     = mem_phase_q;
        halted_d        = halted_q;
        misalign_d      = misalign_q;
        lat_read_d      = lat_read_q;
        lat_write_d     = lat_write_q;
        lat_reg_write_d = lat_reg_write_q;
        lat_jump_d      = lat_jump_q;
        lat_dest_d      = lat_dest_q;

        case (state_q)
            ST_FETCH: begin
                // An ack only counts once the request has actually been seen high.
                if (!fetch_req_q) begin
                    fetch_req_d = 1'b1;
                end else if (fetch_ack) begin
                    fetch_req_d = 1'b0;
                    state_d     = ST_DECODE;
                end
            end
            ST_DECODE: state_d = ST_EXEC;
            ST_EXEC:   state_d = ST_MEM;
            ST_MEM: begin
                // Execute drops its flags after EXEC, so capture them in the first MEM cycle.
                if (!mem_phase_q) begin
                    mem_phase_d     = 1'b1;
                    lat_read_d      = mem_read_enabled;
                    lat_write_d     = mem_write_enabled;
                    lat_reg_write_d = reg_write_enabled;
                    lat_jump_d      = is_jump_enabled;
                    lat_dest_d      = jump_dest;
                    if (!(mem_read_enabled || mem_write_enabled)) begin
                        state_d = ST_WRITE;
                    end
                end else if (mem_req && mem_ack) begin
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                mem_phase_d = 1'b0;
                instret_d   = instret_q + 32'd1;
                if (lat_jump_q && is_misaligned(lat_dest_q)) begin
                    misalign_d = 1'b1;
                    halted_d   = 1'b1;
                    state_d    = ST_HALT;
                end else begin
                    pc_d = lat_jump_q ? lat_dest_q : pc_q + PC_STEP;
                    if (halt_req) begin
                        halted_d = 1'b1;
                        state_d  = ST_HALT;
                    end else begin
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_HALT: begin
                fetch_req_d = 1'b0;
                mem_phase_d = 1'b0;
            end
            default: begin
                fetch_req_d = 1'b0;
                mem_phase_d = 1'b0;
                halted_d    = 1'b1;
                state_d     = ST_HALT;
            end
        endcase
    end

    assign state      = state_q;
    assign pc         = pc_q;
    assign instret    = instret_q;
    assign fetch_req  = fetch_req_q;
    assign halted     = halted_q;
    assign misalign   = misalign_q;
    assign mem_req    = (state_q == ST_MEM) && mem_phase_q && (lat_read_q || lat_write_q);
    assign mem_we     = mem_req && lat_write_q;
    assign reg_commit = (state_q == ST_WRITE) && lat_reg_write_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Scoreboard bench for core_sequencer: directed instructions queue expected
// output snapshots by cycle, and a negedge monitor compares them as they come due.
module tb_core_sequencer;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [2:0]  state;
    logic [31:0] pc;
    logic        fetch_req, fetch_ack;
    logic        mem_req, mem_we, mem_ack;
    logic        mem_read_enabled, mem_write_enabled, reg_write_enabled, is_jump_enabled;
    logic [31:0] jump_dest;
    logic        halt_req;
    logic        reg_commit, halted, misalign;
    logic [31:0] instret;

    int cyc = 0;
    int n_vectors = 0;
    int n_miscompares = 0;

    typedef struct {
        int          at;
        string       name;
        logic [2:0]  st;
        logic [31:0] pcv;
        logic        fr, mr, mw, rc, hl, ms;
        logic [31:0] ic;
        logic        ci;
    } exp_t;

    exp_t exp_q[$];

    core_sequencer #(.RESET_PC(32'h0000_0000)) dut (
        .clk               (clk),
        .rstn              (rstn),
        .state             (state),
        .pc                (pc),
        .fetch_req         (fetch_req),
        .fetch_ack         (fetch_ack),
        .mem_req           (mem_req),
        .mem_we            (mem_we),
        .mem_ack           (mem_ack),
        .mem_read_enabled  (mem_read_enabled),
        .mem_write_enabled (mem_write_enabled),
        .reg_write_enabled (reg_write_enabled),
        .is_jump_enabled   (is_jump_enabled),
        .jump_dest         (jump_dest),
        .halt_req          (halt_req),
        .reg_commit        (reg_commit),
        .halted            (halted),
        .misalign          (misalign),
        .instret           (instret)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic stepN(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pushExpect(input int at, input string nm, input logic [2:0] st,
                              input logic [31:0] pcv, input logic fr, input logic mr,
                              input logic mw, input logic rc, input logic hl, input logic ms,
                              input logic [31:0] ic, input logic ci);
        exp_t e;
        int   i;
        e.at = at; e.name = nm; e.st = st; e.pcv = pcv;
        e.fr = fr; e.mr = mr; e.mw = mw; e.rc = rc; e.hl = hl; e.ms = ms;
        e.ic = ic; e.ci = ci;
        i = exp_q.size();
        while (i > 0 && exp_q[i-1].at > at) i--;
        exp_q.insert(i, e);
    endtask

    task automatic checkOutput(input exp_t e);
        logic ok;
        n_vectors++;
        ok = (e.at == cyc) && (state === e.st) && (pc === e.pcv) && (fetch_req === e.fr) &&
             (mem_req === e.mr) && (mem_we === e.mw) && (reg_commit === e.rc) &&
             (halted === e.hl) && (misalign === e.ms) && (!e.ci || instret === e.ic);
        if (!ok) begin
            n_miscompares++;
            $display("[TB] FAIL %s cyc=%0d/%0d got st=%0d pc=%h freq=%b mreq=%b we=%b rc=%b halt=%b mis=%b iret=%0d, need st=%0d pc=%h freq=%b mreq=%b we=%b rc=%b halt=%b mis=%b iret=%0d",
                     e.name, cyc, e.at, state, pc, fetch_req, mem_req, mem_we, reg_commit,
                     halted, misalign, instret, e.st, e.pcv, e.fr, e.mr, e.mw, e.rc, e.hl,
                     e.ms, e.ic);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0 && exp_q[0].at <= cyc) begin
                e = exp_q.pop_front();
                checkOutput(e);
            end
        end
    end

    task automatic clearInputs();
        fetch_ack = 0; mem_ack = 0; halt_req = 0;
        mem_read_enabled = 0; mem_write_enabled = 0; reg_write_enabled = 0;
        is_jump_enabled = 0; jump_dest = 32'h0;
    endtask

    task automatic doReset();
        rstn = 1'b0;
        clearInputs();
        pushExpect(cyc + 1, "reset", 3'd0, 32'h0, 0, 0, 0, 0, 0, 0, 32'd0, 1);
        stepN(1);
        rstn = 1'b1;
    endtask

    // Called on the negedge where FETCH has just been entered; returns on the next one.
    // Stray acks and a halt request outside WRITE are driven on purpose and must be ignored.
    task automatic applyStimulus(input int fw, input logic rd, input logic wr, input logic rw,
                                 input logic jmp, input logic [31:0] dest, input int mw,
                                 input logic hreq);
        fetch_ack = 1'b1;
        stepN(1);
        fetch_ack = (fw == 0);
        if (fw > 0) begin
            stepN(fw);
            fetch_ack = 1'b1;
        end
        stepN(1);
        fetch_ack = 1'b0;
        halt_req = 1'b1;
        mem_read_enabled = rd; mem_write_enabled = wr; reg_write_enabled = rw;
        is_jump_enabled = jmp; jump_dest = dest;
        stepN(1);
        halt_req = hreq;
        stepN(1);
        mem_ack = 1'b1;
        stepN(1);
        mem_read_enabled = 0; mem_write_enabled = 0; reg_write_enabled = 0;
        is_jump_enabled = 0; jump_dest = 32'hDEAD_BEEF;
        mem_ack = 1'b0;
        if (rd || wr) begin
            mem_ack = (mw == 0);
            if (mw > 0) begin
                stepN(mw);
                mem_ack = 1'b1;
            end
            stepN(1);
            mem_ack = 1'b0;
        end
        stepN(1);
        halt_req = 1'b0;
    endtask

    initial begin : watchdog
        #100000;
        n_miscompares++;
        $display("[TB] FAIL watchdog timeout at cycle %0d, %0d checks pending", cyc, exp_q.size());
        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

    initial begin
        int s;
        clearInputs();
        @(negedge clk);
        doReset();

        s = cyc;
        pushExpect(s+1, "alu_req_up",  3'd0, 32'h0, 1, 0, 0, 0, 0, 0, 32'd0, 1);
        pushExpect(s+2, "alu_decode",  3'd1, 32'h0, 0, 0, 0, 0, 0, 0, 32'd0, 1);
        pushExpect(s+3, "alu_exec",    3'd2, 32'h0, 0, 0, 0, 0, 0, 0, 32'd0, 1);
        pushExpect(s+4, "alu_mem",     3'd3, 32'h0, 0, 0, 0, 0, 0, 0, 32'd0, 1);
        pushExpect(s+5, "alu_write",   3'd4, 32'h0, 0, 0, 0, 1, 0, 0, 32'd0, 1);
        pushExpect(s+6, "alu_retired", 3'd0, 32'h4, 0, 0, 0, 0, 0, 0, 32'd1, 1);
        applyStimulus(0, 0, 0, 1, 0, 32'h0, 0, 0);

        s = cyc;
        pushExpect(s+4,  "load_mem1",    3'd3, 32'h4, 0, 0, 0, 0, 0, 0, 32'd1, 1);
        pushExpect(s+5,  "load_req1",    3'd3, 32'h4, 0, 1, 0, 0, 0, 0, 32'd1, 1);
        pushExpect(s+8,  "load_req4",    3'd3, 32'h4, 0, 1, 0, 0, 0, 0, 32'd1, 1);
        pushExpect(s+9,  "load_write",   3'd4, 32'h4, 0, 0, 0, 1, 0, 0, 32'd1, 1);
        pushExpect(s+10, "load_retired", 3'd0, 32'h8, 0, 0, 0, 0, 0, 0, 32'd2, 1);
        applyStimulus(0, 1, 0, 1, 0, 32'h0, 3, 0);

        s = cyc;
        pushExpect(s+3, "store_fwait",   3'd0, 32'h8, 1, 0, 0, 0, 0, 0, 32'd2, 1);
        pushExpect(s+4, "store_decode",  3'd1, 32'h8, 0, 0, 0, 0, 0, 0, 32'd2, 1);
        pushExpect(s+7, "store_req_we",  3'd3, 32'h8, 0, 1, 1, 0, 0, 0, 32'd2, 1);
        pushExpect(s+8, "store_write",   3'd4, 32'h8, 0, 0, 0, 0, 0, 0, 32'd2, 1);
        pushExpect(s+9, "store_retired", 3'd0, 32'hC, 0, 0, 0, 0, 0, 0, 32'd3, 1);
        applyStimulus(2, 1, 1, 0, 0, 32'h0, 0, 0);

        s = cyc;
        pushExpect(s+5, "branch_write", 3'd4, 32'hC,   0, 0, 0, 0, 0, 0, 32'd3, 1);
        pushExpect(s+6, "branch_taken", 3'd0, 32'h100, 0, 0, 0, 0, 0, 0, 32'd4, 1);
        applyStimulus(0, 0, 0, 0, 1, 32'h100, 0, 0);

        s = cyc;
        pushExpect(s+5, "jal_write", 3'd4, 32'h100,       0, 0, 0, 1, 0, 0, 32'd4, 1);
        pushExpect(s+6, "jal_top",   3'd0, 32'hFFFF_FFFC, 0, 0, 0, 0, 0, 0, 32'd5, 1);
        applyStimulus(0, 0, 0, 1, 1, 32'hFFFF_FFFC, 0, 0);

        s = cyc;
        pushExpect(s+5, "wrap_write", 3'd4, 32'hFFFF_FFFC, 0, 0, 0, 0, 0, 0, 32'd5, 1);
        pushExpect(s+6, "wrap_pc0",   3'd0, 32'h0,         0, 0, 0, 0, 0, 0, 32'd6, 1);
        applyStimulus(0, 0, 0, 0, 0, 32'h0, 0, 0);

        s = cyc;
        pushExpect(s+5,  "halt_write", 3'd4, 32'h0, 0, 0, 0, 1, 0, 0, 32'd6, 1);
        pushExpect(s+6,  "halt_enter", 3'd5, 32'h4, 0, 0, 0, 0, 1, 0, 32'd7, 1);
        pushExpect(s+12, "halt_hold",  3'd5, 32'h4, 0, 0, 0, 0, 1, 0, 32'd7, 1);
        applyStimulus(0, 0, 0, 1, 0, 32'h0, 0, 1);
        fetch_ack = 1'b1; mem_ack = 1'b1;
        stepN(8);
        clearInputs();

        doReset();
        s = cyc;
        pushExpect(s+5,  "mis_write", 3'd4, 32'h0, 0, 0, 0, 1, 0, 0, 32'd0, 1);
        pushExpect(s+6,  "mis_halt",  3'd5, 32'h0, 0, 0, 0, 0, 1, 1, 32'd0, 0);
        pushExpect(s+16, "mis_hold1", 3'd5, 32'h0, 0, 0, 0, 0, 1, 1, 32'd0, 0);
        pushExpect(s+26, "mis_hold2", 3'd5, 32'h0, 0, 0, 0, 0, 1, 1, 32'd0, 0);
        applyStimulus(0, 0, 0, 1, 1, 32'h102, 0, 0);
        fetch_ack = 1'b1; mem_ack = 1'b1;
        stepN(20);
        clearInputs();

        doReset();
        s = cyc;
        pushExpect(s+5, "rst_mid_req",  3'd3, 32'h0, 0, 1, 0, 0, 0, 0, 32'd0, 1);
        pushExpect(s+7, "rst_mid",      3'd0, 32'h0, 0, 0, 0, 0, 0, 0, 32'd0, 1);
        pushExpect(s+8, "rst_late_ack", 3'd0, 32'h0, 1, 0, 0, 0, 0, 0, 32'd0, 1);
        pushExpect(s+9, "rst_no_mem",   3'd0, 32'h0, 1, 0, 0, 0, 0, 0, 32'd0, 1);
        fetch_ack = 1'b1;
        stepN(2);
        fetch_ack = 1'b0;
        mem_read_enabled = 1'b1;
        stepN(3);
        mem_read_enabled = 1'b0;
        stepN(1);
        rstn = 1'b0;
        stepN(1);
        rstn = 1'b1;
        mem_ack = 1'b1;
        stepN(1);
        mem_ack = 1'b0;
        stepN(3);

        if (exp_q.size() != 0) begin
            n_miscompares++;
            $display("[TB] FAIL pending_checks got %0d left, need 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule

// File: doc/core_sequencer.md
CORE_SEQUENCER -- requirements
Module: core_sequencer

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, giving the PC loaded on reset.
REQ-002 The block SHALL have port clk  in  1  core clock; all state changes on rising edge.
REQ-003 The block SHALL have port rstn  in  1  reset, synchronous, active-low.
REQ-004 The block SHALL have port state  out  3  current core state, broadcast to fetch/decode/execute/write stages.
REQ-005 The block SHALL have port pc  out  32  architectural PC of the instruction in flight.
REQ-006 The block SHALL have ports fetch_req  out  1  instruction-fetch request, and fetch_ack  in  1  fetch complete.
REQ-007 The block SHALL have ports mem_req  out  1  data-memory request, mem_we  out  1  store when high, and mem_ack  in  1  access complete.
REQ-008 The block SHALL have inputs mem_read_enabled, mem_write_enabled, reg_write_enabled and is_jump_enabled (1 bit each), and jump_dest (32 bits), all from execute.
REQ-009 The block SHALL have input halt_req  1  stop request, and outputs reg_commit  1  register-file write strobe, halted  1  sticky halt, misalign  1  sticky misaligned-target flag, and instret  32  retired-instruction count.

Function
REQ-010 States SHALL be FETCH=0, DECODE=1, EXEC=2, MEM=3, WRITE=4, HALT=5; codes 6-7 SHALL go to HALT on the next edge.
REQ-011 FETCH: fetch_req SHALL be registered high starting the cycle after FETCH is entered and held until fetch_ack is sampled high; then fetch_req SHALL drop and state SHALL become DECODE.
REQ-012 fetch_ack SHALL be ignored while fetch_req is low, including an ack in the same cycle fetch_req first rises from low.
REQ-013 DECODE and EXEC SHALL each last exactly 1 cycle: DECODE->EXEC->MEM.
REQ-014 In the first MEM cycle, the block SHALL latch all execute flags and jump_dest, because execute clears its write/jump flags outside EXEC; later decisions SHALL use only the latched copies.
REQ-015 MEM with latched read=0 and write=0 SHALL last 1 cycle and then go to WRITE.
REQ-016 MEM with latched read or write SHALL assert mem_req from the second MEM cycle, with mem_we equal to latched write, and hold both stable until mem_ack is sampled high; then mem_req SHALL drop and state SHALL become WRITE.
REQ-017 If both latched read and write are high, the access SHALL be treated as a store (mem_we=1).
REQ-018 WRITE SHALL last 1 cycle: reg_commit = latched reg_write_enabled for that cycle only; instret increments by 1 (wrapping 2^32-1 -> 0).
REQ-019 At the end of WRITE, pc SHALL become latched jump_dest if latched jump is set, else pc+4 modulo 2^32 (32'hFFFF_FFFC -> 0).
REQ-020 If latched jump is set and jump_dest[1:0] != 0, the block SHALL not update pc and SHALL set misalign, set halted, and go to HALT instead of FETCH.
REQ-021 halt_req SHALL be sampled only in WRITE; if high, the instruction SHALL still retire normally and the next state SHALL be HALT.
REQ-022 HALT SHALL be absorbing; outputs SHALL hold, with fetch_req=mem_req=reg_commit=0, until reset.
REQ-023 Minimum instruction latency SHALL be 6 cycles (FETCH 2 with same-cycle ack, DECODE 1, EXEC 1, MEM 1, WRITE 1), plus 1 cycle plus memory wait for a load or store.

Reset
REQ-024 When rstn=0 at an edge: state=FETCH, pc=RESET_PC, fetch_req=mem_req=mem_we=reg_commit=0, halted=misalign=0, instret=0, all latched flags=0.
REQ-025 Reset mid-handshake SHALL abandon the transaction; any ack arriving after reset SHALL be ignored per REQ-012.

Structure
REQ-026 State encodings SHALL reside in the shared def package, used unchanged by execute and the other stages.
REQ-027 The block SHALL be one module with no sub-modules; the 32-bit PC incrementer SHALL be inline.

Verification
REQ-028 Straight-line ALU op with fetch_ack on the first request cycle -> states 0,0,1,2,3,4,0; reg_commit pulses once; pc 0->4; instret=1.
REQ-029 Load with mem_ack delayed 3 cycles -> mem_req high exactly 4 cycles with mem_we=0; WRITE follows the ack cycle; total latency 10 cycles.
REQ-030 Taken branch, jump_dest=32'h100, reg_write_enabled=0 -> pc=32'h100, reg_commit stays 0; execute flags cleared after MEM cycle 1 do not change the result.
REQ-031 jalr with jump_dest=32'h102 -> pc unchanged, misalign=1, halted=1, state=5 held for 20 cycles with no requests.
REQ-032 rstn low for 1 cycle during a pending mem_req, with mem_ack high the next cycle -> state=FETCH, pc=RESET_PC, mem_req=0, ack ignored; pc=32'hFFFF_FFFC non-jump -> pc wraps to 0.
